// File: rtl/ram_scan_display_if.sv
// Signal bundle between the RAM-monitor display block and the board/RAM side.
// The master drives switches, write-port mirror and read data; the slave returns the read address and HEX digits.
interface ram_scan_display_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 4
);
  localparam int ADDR_DIGITS = (ADDR_WIDTH + 3) / 4;
  localparam int DATA_DIGITS = (DATA_WIDTH + 3) / 4;

  logic                     scan_en;
  logic [ADDR_WIDTH-1:0]    manual_addr;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [DATA_WIDTH-1:0]    re_data;
  logic [ADDR_WIDTH-1:0]    re_addr;
  logic [7*ADDR_DIGITS-1:0] re_addrHEX;
  logic [7*ADDR_DIGITS-1:0] wr_addrHEX;
  logic [7*DATA_DIGITS-1:0] wr_dataHEX;
  logic [7*DATA_DIGITS-1:0] re_dataHEX;

  modport master (
    output scan_en, manual_addr, wr_addr, wr_data, re_data,
    input  re_addr, re_addrHEX, wr_addrHEX, wr_dataHEX, re_dataHEX
  );

  modport slave (
    input  scan_en, manual_addr, wr_addr, wr_data, re_data,
    output re_addr, re_addrHEX, wr_addrHEX, wr_dataHEX, re_dataHEX
  );
endinterface

// File: rtl/ram_scan_display.sv
// RAM monitor: generates the read address (manual or auto-scan) and drives registered
// 7-segment digits for write address/data and latency-aligned read address/data.
module ram_scan_display #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 4,
  parameter int SCAN_DIV     = 50_000_000,
  parameter int READ_LATENCY = 1,
  parameter bit BLANK_LZ     = 1'b0
) (
  input logic               clk,
  input logic               reset,
  ram_scan_display_if.slave bus
);
  localparam int ADDR_DIGITS = (ADDR_WIDTH + 3) / 4;
  localparam int DATA_DIGITS = (DATA_WIDTH + 3) / 4;
  localparam int TICK_W      = $clog2(SCAN_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] re_addr_q, re_addr_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [ADDR_WIDTH-1:0] addr_aligned;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // upper_zero: this nibble and every more significant one are zero.
  function automatic logic [6:0] digit_code(input logic [3:0] nib, input logic upper_zero,
                                            input bit leading);
    if (BLANK_LZ && leading && upper_zero) return 7'b1111111;
    return seg7(nib);
  endfunction

  // NOTE: every path through this block assigns a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    re_addr_d = re_addr_q;
    tick_d    = tick_q;
    case (state_q)
      MANUAL: begin
        tick_d = '0;
        if (bus.scan_en) state_d   = SCAN;
        else             re_addr_d = bus.manual_addr;
      end
      SCAN: begin
        // Leaving scan mode takes priority over a terminal tick on the same edge.
        if (!bus.scan_en) begin
          state_d   = MANUAL;
          re_addr_d = bus.manual_addr;
          tick_d    = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          re_addr_d = re_addr_q + ADDR_WIDTH'(1);
        end else begin
          tick_d    = tick_q + TICK_W'(1);
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MANUAL;
      re_addr_q <= '0;
      tick_q    <= '0;
    end else begin
      state_q   <= state_d;
      re_addr_q <= re_addr_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.re_addr = re_addr_q;

  if (READ_LATENCY == 0) begin : g_no_pipe
    assign addr_aligned = re_addr_q;
  end else begin : g_pipe
    logic [ADDR_WIDTH-1:0] pipe_q [READ_LATENCY];
    // NOTE: the pipe is a handful of flops rather than a RAM, so it is reset; the first pair shown after reset is then address 0.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= re_addr_q;
        for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign addr_aligned = pipe_q[READ_LATENCY-1];
  end

  logic [4*ADDR_DIGITS-1:0] re_addr_ext, wr_addr_ext;
  logic [4*DATA_DIGITS-1:0] re_data_ext, wr_data_ext;
  logic [7*ADDR_DIGITS-1:0] re_addr_hex_d, wr_addr_hex_d, addr_hex_rst;
  logic [7*DATA_DIGITS-1:0] re_data_hex_d, wr_data_hex_d, data_hex_rst;
  logic [7*ADDR_DIGITS-1:0] re_addr_hex_q, wr_addr_hex_q;
  logic [7*DATA_DIGITS-1:0] re_data_hex_q, wr_data_hex_q;

  assign re_addr_ext = (4*ADDR_DIGITS)'(addr_aligned);
  assign wr_addr_ext = (4*ADDR_DIGITS)'(bus.wr_addr);
  assign re_data_ext = (4*DATA_DIGITS)'(bus.re_data);
  assign wr_data_ext = (4*DATA_DIGITS)'(bus.wr_data);

  for (genvar k = 0; k < ADDR_DIGITS; k++) begin : g_addr_dig
    assign re_addr_hex_d[7*k +: 7] =
      digit_code(re_addr_ext[4*k +: 4], (re_addr_ext >> (4*k)) == '0, k > 0);
    assign wr_addr_hex_d[7*k +: 7] =
      digit_code(wr_addr_ext[4*k +: 4], (wr_addr_ext >> (4*k)) == '0, k > 0);
    assign addr_hex_rst[7*k +: 7] = digit_code(4'h0, 1'b1, k > 0);
  end

  for (genvar k = 0; k < DATA_DIGITS; k++) begin : g_data_dig
    assign re_data_hex_d[7*k +: 7] =
      digit_code(re_data_ext[4*k +: 4], (re_data_ext >> (4*k)) == '0, k > 0);
    assign wr_data_hex_d[7*k +: 7] =
      digit_code(wr_data_ext[4*k +: 4], (wr_data_ext >> (4*k)) == '0, k > 0);
    assign data_hex_rst[7*k +: 7] = digit_code(4'h0, 1'b1, k > 0);
  end

  // Delayed address and read data are captured on the same edge so they always display as a pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      re_addr_hex_q <= addr_hex_rst;
      wr_addr_hex_q <= addr_hex_rst;
      re_data_hex_q <= data_hex_rst;
      wr_data_hex_q <= data_hex_rst;
    end else begin
      re_addr_hex_q <= re_addr_hex_d;
      wr_addr_hex_q <= wr_addr_hex_d;
      re_data_hex_q <= re_data_hex_d;
      wr_data_hex_q <= wr_data_hex_d;
    end
  end

  assign bus.re_addrHEX = re_addr_hex_q;
  assign bus.wr_addrHEX = wr_addr_hex_q;
  assign bus.re_dataHEX = re_data_hex_q;
  assign bus.wr_dataHEX = wr_data_hex_q;
endmodule
